// File: rtl/instr_queue_register_if.sv
// Instruction storage bus: generator-side requests and storage-side responses.
interface instr_queue_register_if #(
    parameter int DEPTH     = 32,
    parameter int OP_WIDTH  = 32,
    parameter int OPC_WIDTH = 4
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = OPC_WIDTH + 2 * OP_WIDTH;

    logic                 queue_mode;
    logic                 load_en;
    logic [OPC_WIDTH-1:0] opcode;
    logic [OP_WIDTH-1:0]  operand_a;
    logic [OP_WIDTH-1:0]  operand_b;
    logic [AW-1:0]        write_pointer;
    logic                 read_en;
    logic [AW-1:0]        read_pointer;
    logic                 load_ready;
    logic [IW-1:0]        instruction_word;
    logic                 instr_valid;
    logic                 read_error;
    logic [AW:0]          count;

    modport master (
        output queue_mode, load_en, opcode, operand_a, operand_b,
               write_pointer, read_en, read_pointer,
        input  load_ready, instruction_word, instr_valid, read_error, count
    );

    modport slave (
        input  queue_mode, load_en, opcode, operand_a, operand_b,
               write_pointer, read_en, read_pointer,
        output load_ready, instruction_word, instr_valid, read_error, count
    );
endinterface

// File: rtl/instr_queue_register.sv
// Instruction-word store: addressed random access or FIFO, with per-entry
// valid bits, registered read port, occupancy count and read-error pulse.
module instr_queue_register #(
    parameter int DEPTH            = 32,
    parameter int OP_WIDTH         = 32,
    parameter int OPC_WIDTH        = 4,
    parameter bit FORCE_LOAD_ERROR = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    instr_queue_register_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IW = OPC_WIDTH + 2 * OP_WIDTH;
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [IW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count_q;
    logic             mode_q;

    logic             flush;
    logic             push;
    logic             pop;
    logic             rd_ok;
    logic             rd_err;
    logic             new_entry;
    logic [AW-1:0]    widx;
    logic [AW-1:0]    ridx;
    logic [IW-1:0]    wdata;
    logic [AW:0]      count_next;

    always_comb begin
        flush      = reset || (bus.queue_mode != mode_q);
        push       = 1'b0;
        pop        = 1'b0;
        rd_ok      = 1'b0;
        rd_err     = 1'b0;
        new_entry  = 1'b0;
        widx       = wptr;
        ridx       = rptr;
        wdata      = FORCE_LOAD_ERROR ? {bus.opcode, bus.operand_a, bus.operand_a}
                                      : {bus.opcode, bus.operand_a, bus.operand_b};
        if (!flush) begin
            if (bus.queue_mode) begin
                push   = bus.load_en && (count_q < FULL);
                rd_ok  = bus.read_en && (count_q != '0);
                rd_err = bus.read_en && (count_q == '0);
                pop    = rd_ok;
            end else begin
                widx   = bus.write_pointer;
                ridx   = bus.read_pointer;
                push   = bus.load_en && ({1'b0, bus.write_pointer} < FULL);
                rd_ok  = bus.read_en && ({1'b0, bus.read_pointer} < FULL) && valid[bus.read_pointer];
                rd_err = bus.read_en && !rd_ok;
            end
            new_entry = push && !valid[widx];
        end
        count_next = count_q + (AW + 1)'(new_entry) - (AW + 1)'(pop);
    end

    // Mode-toggle cycles behave exactly like reset, so a write is never accepted then.
    assign bus.load_ready = reset || !bus.queue_mode || (count_q < FULL);
    assign bus.count      = count_q;

    always_ff @(posedge clk) begin
        mode_q <= bus.queue_mode;
        if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid                <= '0;
            wptr                 <= '0;
            rptr                 <= '0;
            count_q              <= '0;
            bus.instruction_word <= '0;
            bus.instr_valid      <= 1'b0;
            bus.read_error       <= 1'b0;
        end else begin
            bus.instr_valid <= rd_ok;
            bus.read_error  <= rd_err;
            // mem is sampled before this edge's write, giving read-before-write.
            if (rd_ok) begin
                bus.instruction_word <= mem[ridx];
            end else if (rd_err) begin
                bus.instruction_word <= '0;
            end
            if (push) begin
                mem[widx]   <= wdata;
                valid[widx] <= 1'b1;
                if (bus.queue_mode) begin
                    wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
                end
            end
            if (pop) begin
                valid[rptr] <= 1'b0;
                rptr        <= (rptr == LAST) ? '0 : rptr + 1'b1;
            end
            count_q <= count_next;
        end
    end
endmodule

// File: tb/tb_instr_queue_register.sv
// Randomised scoreboard bench for instr_queue_register against a queue/array model.
module tb_instr_queue_register;
    localparam int DEPTH     = 5;
    localparam int OP_WIDTH  = 32;
    localparam int OPC_WIDTH = 4;
    localparam int AW        = $clog2(DEPTH);
    localparam int IW        = OPC_WIDTH + 2 * OP_WIDTH;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_queue_register_if #(.DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH), .OPC_WIDTH(OPC_WIDTH)) bus ();

    instr_queue_register #(
        .DEPTH(DEPTH), .OP_WIDTH(OP_WIDTH), .OPC_WIDTH(OPC_WIDTH), .FORCE_LOAD_ERROR(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit            err;
        logic [IW-1:0] word;
    } resp_t;

    resp_t         sb [$];
    int            checks = 0;
    int            errors = 0;

    logic [IW-1:0] amem [8];
    bit            aval [8];
    logic [IW-1:0] fifo [$];
    bit            mprev = 1'b0;
    logic [IW-1:0] mword = '0;
    bit            armed = 1'b0;
    bit            cur_qm = 1'b0;

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_count();
        int c = fifo.size();
        for (int i = 0; i < DEPTH; i++) if (aval[i]) c++;
        return c;
    endfunction

    function automatic logic [IW-1:0] mk(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        return {o, a, b};
    endfunction

    function automatic logic [IW-1:0] rnd_word();
        return IW'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic model_step(input bit rst, input bit qm, input bit le, input logic [IW-1:0] w,
                              input logic [AW-1:0] wp, input bit re, input logic [AW-1:0] rp);
        int  n;
        bit  do_push;
        if (rst || qm != mprev) begin
            for (int i = 0; i < 8; i++) aval[i] = 1'b0;
            fifo.delete();
            mword = '0;
        end else if (!qm) begin
            if (re) begin
                if (int'(rp) < DEPTH && aval[rp]) begin
                    sb.push_back('{1'b0, amem[rp]});
                    mword = amem[rp];
                end else begin
                    sb.push_back('{1'b1, '0});
                    mword = '0;
                end
            end
            if (le && int'(wp) < DEPTH) begin
                amem[wp] = w;
                aval[wp] = 1'b1;
            end
        end else begin
            n       = fifo.size();
            do_push = le && (n < DEPTH);
            if (re) begin
                if (n > 0) begin
                    sb.push_back('{1'b0, fifo[0]});
                    mword = fifo[0];
                    void'(fifo.pop_front());
                end else begin
                    sb.push_back('{1'b1, '0});
                    mword = '0;
                end
            end
            if (do_push) fifo.push_back(w);
        end
        mprev = qm;
        if (rst) armed = 1'b1;
    endtask

    task automatic cycle(input bit rst, input bit qm, input bit le, input logic [IW-1:0] w,
                         input logic [AW-1:0] wp, input bit re, input logic [AW-1:0] rp);
        bit exp_lr;
        @(negedge clk);
        if (armed) begin
            check("count", IW'(bus.count), IW'(model_count()));
            check("instruction_word", bus.instruction_word, mword);
        end
        reset             = rst;
        bus.queue_mode    = qm;
        bus.load_en       = le;
        {bus.opcode, bus.operand_a, bus.operand_b} = w;
        bus.write_pointer = wp;
        bus.read_en       = re;
        bus.read_pointer  = rp;
        #1;
        if (armed || rst) begin
            exp_lr = rst || !qm || (model_count() < DEPTH);
            check("load_ready", IW'(bus.load_ready), IW'(exp_lr));
        end
        model_step(rst, qm, le, w, wp, re, rp);
    endtask

    task automatic idle(input bit rst, input bit qm);
        cycle(rst, qm, 1'b0, '0, '0, 1'b0, '0);
    endtask
    task automatic qpush(input logic [IW-1:0] w);
        cycle(1'b0, 1'b1, 1'b1, w, '0, 1'b0, '0);
    endtask
    task automatic qpop();
        cycle(1'b0, 1'b1, 1'b0, '0, '0, 1'b1, '0);
    endtask
    task automatic qboth(input logic [IW-1:0] w);
        cycle(1'b0, 1'b1, 1'b1, w, '0, 1'b1, '0);
    endtask
    task automatic awr(input logic [AW-1:0] wp, input logic [IW-1:0] w);
        cycle(1'b0, 1'b0, 1'b1, w, wp, 1'b0, '0);
    endtask
    task automatic ard(input logic [AW-1:0] rp);
        cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, rp);
    endtask

    // Monitor: every output pulse must match the oldest outstanding expectation.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1 || bus.read_error === 1'b1) begin
                check("pulse_exclusive", IW'(bus.instr_valid & bus.read_error), '0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response actual valid=%0b err=%0b required none at %0t",
                             bus.instr_valid, bus.read_error, $time);
                end else begin
                    r = sb.pop_front();
                    check("resp_error_flag", IW'(bus.read_error), IW'(r.err));
                    check("resp_valid_flag", IW'(bus.instr_valid), IW'(!r.err));
                    check("resp_word", bus.instruction_word, r.word);
                end
            end
        end
    end

    initial begin
        logic [IW-1:0] w;
        reset = 1'b1;
        bus.queue_mode = 1'b0; bus.load_en = 1'b0; bus.read_en = 1'b0;
        bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
        bus.write_pointer = '0; bus.read_pointer = '0;
        for (int i = 0; i < 8; i++) begin amem[i] = '0; aval[i] = 1'b0; end

        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // Addressed: empty / out-of-range reads, write, rewrite, read-before-write
        ard(3'd5);
        ard(3'd2);
        awr(3'd3, mk(4'h2, 32'd10, 32'd20));
        ard(3'd3);
        awr(3'd3, mk(4'h7, 32'd1, 32'd2));
        cycle(1'b0, 1'b0, 1'b1, mk(4'h9, 32'd9, 32'd9), 3'd3, 1'b1, 3'd3);
        ard(3'd3);
        awr(3'd6, mk(4'h1, 32'd6, 32'd6));
        ard(3'd6);
        awr(3'd4, mk(4'h3, 32'd4, 32'd44));
        ard(3'd4);

        // Queue: fill, overflow drop, drain past empty
        idle(1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) qpush(mk(4'(i), 32'(i * 3), 32'(i * 7)));
        for (int i = 0; i < DEPTH + 1; i++) qpop();
        // Full push+pop, then empty push+pop
        for (int i = 0; i < DEPTH; i++) qpush(rnd_word());
        qboth(rnd_word());
        for (int i = 0; i < DEPTH - 1; i++) qpop();
        qboth(rnd_word());
        qboth(rnd_word());
        qpop();
        qpop();
        // Mode toggle with read in flight, then reset mid-read
        for (int i = 0; i < 3; i++) qpush(rnd_word());
        ard(3'd0);
        ard(3'd0);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) qpush(rnd_word());
        qpop();
        cycle(1'b1, 1'b1, 1'b0, '0, '0, 1'b1, '0);
        qpop();
        qpop();

        // Random queue traffic across many pointer wraps
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), rnd_word(), AW'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end

        // Random mixed traffic with occasional resets and mode toggles
        cur_qm = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 31) == 0) cur_qm = ~cur_qm;
            w = rnd_word();
            cycle(1'($urandom_range(0, 63) == 0), cur_qm, 1'($urandom_range(0, 1)), w,
                  AW'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end

        idle(1'b0, cur_qm);
        idle(1'b0, cur_qm);
        @(negedge clk);
        #2;
        check("scoreboard_drained", IW'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
